// File: rtl/dwc_ddrphy_memreset_seq_if.sv
// Bundles the sequencer's CSR request/status and POR-cell control/status signals.
// master: the sequencer (drives POR controls and status); slave: its environment.
// Carries no clock or reset; those remain plain ports on the sequencer.
interface dwc_ddrphy_memreset_seq_if;
  logic       PwrOkDlyd;
  logic       SeqStart;
  logic       MemResetReq;
  logic       DCTSane;
  logic       PORMemReset;
  logic       SetDCTSanePulse;
  logic       ClrPORMemReset;
  logic       DCTMemReset;
  logic       SeqBusy;
  logic       SeqDone;
  logic       SeqErr;
  logic [2:0] SeqState;

  modport master (
    input  PwrOkDlyd, SeqStart, MemResetReq, DCTSane, PORMemReset,
    output SetDCTSanePulse, ClrPORMemReset, DCTMemReset,
    output SeqBusy, SeqDone, SeqErr, SeqState
  );

  modport slave (
    output PwrOkDlyd, SeqStart, MemResetReq, DCTSane, PORMemReset,
    input  SetDCTSanePulse, ClrPORMemReset, DCTMemReset,
    input  SeqBusy, SeqDone, SeqErr, SeqState
  );
endinterface

// File: rtl/dwc_ddrphy_memreset_seq.sv
// Core-domain sequencer arming DCTSane, clearing the POR memory reset, then handing MemReset to CSR.
// Latency: SeqStart->SeqBusy 1 cycle; async status inputs SYNC_STAGES+1 cycles to a state change.
// No backpressure: status inputs are levels; every output is a registered, glitch-free level.
module dwc_ddrphy_memreset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_CYC   = 4,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                             DfiClk,
  input  logic                             Reset_X,
  dwc_ddrphy_memreset_seq_if.master        seqIf
);

  localparam int MAX_AB  = (TIMEOUT_CYC > PULSE_CYC) ? TIMEOUT_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT     = CNT_W'(HOLD_CYC);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PWR  = 3'd1,
    SET_SANE  = 3'd2,
    WAIT_SANE = 3'd3,
    CLR_POR   = 3'd4,
    WAIT_POR  = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;

  state_t state, nextState;

  logic [SYNC_STAGES-1:0] pwrSync, saneSync, porSync;
  logic                   pwrOk, saneOk, porHeld;

  logic [CNT_W-1:0] cnt, holdCnt;

  logic setSaneQ, clrPorQ, dctMemResetQ, busyQ, doneQ, errQ;
  logic setSaneD, clrPorD, dctMemResetD, busyD, doneD, errD;

  logic pwrLost, timedOut, holdMet;

  // Synchronize the asynchronous power-good and POR-cell status levels into DfiClk.
  always_ff @(posedge DfiClk or negedge Reset_X) begin
    if (!Reset_X) begin
      pwrSync  <= '0;
      saneSync <= '0;
      porSync  <= '0;
    end else begin
      pwrSync  <= {pwrSync[SYNC_STAGES-2:0],  seqIf.PwrOkDlyd};
      saneSync <= {saneSync[SYNC_STAGES-2:0], seqIf.DCTSane};
      porSync  <= {porSync[SYNC_STAGES-2:0],  seqIf.PORMemReset};
    end
  end

  assign pwrOk   = pwrSync[SYNC_STAGES-1];
  assign saneOk  = saneSync[SYNC_STAGES-1];
  assign porHeld = porSync[SYNC_STAGES-1];

  assign pwrLost  = !pwrOk && (state inside {SET_SANE, WAIT_SANE, CLR_POR, WAIT_POR, DONE});
  assign timedOut = (cnt == TIMEOUT_LAST);
  // A 1->0 request at this edge leaves DCTMemReset high for at least HOLD_CYC full cycles.
  assign holdMet  = (holdCnt >= HOLD_LAST);

  // State register, shared cycle counter, hold counter and registered outputs.
  always_ff @(posedge DfiClk or negedge Reset_X) begin
    if (!Reset_X) begin
      state        <= IDLE;
      cnt          <= '0;
      holdCnt      <= '0;
      setSaneQ     <= 1'b0;
      clrPorQ      <= 1'b0;
      dctMemResetQ <= 1'b1;
      busyQ        <= 1'b0;
      doneQ        <= 1'b0;
      errQ         <= 1'b0;
    end else begin
      state        <= nextState;
      if (nextState != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (!dctMemResetQ) begin
        holdCnt <= '0;
      end else if (holdCnt != HOLD_SAT) begin
        holdCnt <= holdCnt + 1'b1;
      end
      setSaneQ     <= setSaneD;
      clrPorQ      <= clrPorD;
      dctMemResetQ <= dctMemResetD;
      busyQ        <= busyD;
      doneQ        <= doneD;
      errQ         <= errD;
    end
  end

  // Next state: power loss beats timeout, timeout beats progress.
  always_comb begin
    nextState = state;
    if (pwrLost) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (seqIf.SeqStart) nextState = WAIT_PWR;
        WAIT_PWR:  if (pwrOk) nextState = SET_SANE;
        SET_SANE:  if (cnt == PULSE_LAST) nextState = WAIT_SANE;
        WAIT_SANE: if (timedOut) nextState = ERR;
                   else if (saneOk) nextState = CLR_POR;
        CLR_POR:   if (cnt == PULSE_LAST) nextState = WAIT_POR;
        WAIT_POR:  if (timedOut) nextState = ERR;
                   else if (!porHeld) nextState = DONE;
        DONE:      nextState = DONE;
        ERR:       if (seqIf.SeqStart) nextState = WAIT_PWR;
        default:   nextState = IDLE;
      endcase
    end
  end

  // Output values for the next cycle, decoded from the state being entered.
  always_comb begin
    setSaneD     = (nextState == SET_SANE);
    clrPorD      = (nextState == CLR_POR);
    busyD        = nextState inside {WAIT_PWR, SET_SANE, WAIT_SANE, CLR_POR, WAIT_POR};
    doneD        = (nextState == DONE);
    errD         = errQ;
    dctMemResetD = 1'b1;
    if (nextState == ERR) begin
      errD = 1'b1;
    end else if (nextState == WAIT_PWR && (state == IDLE || state == ERR)) begin
      errD = 1'b0;
    end
    // The CSR request is only honoured once already in DONE and staying there.
    if (state == DONE && nextState == DONE) begin
      dctMemResetD = seqIf.MemResetReq | (dctMemResetQ & ~holdMet);
    end
  end

  assign seqIf.SetDCTSanePulse = setSaneQ;
  assign seqIf.ClrPORMemReset  = clrPorQ;
  assign seqIf.DCTMemReset     = dctMemResetQ;
  assign seqIf.SeqBusy         = busyQ;
  assign seqIf.SeqDone         = doneQ;
  assign seqIf.SeqErr          = errQ;
  assign seqIf.SeqState        = state;

endmodule

// File: tb/tb_dwc_ddrphy_memreset_seq.sv
// Directed-sequence bench with randomized POR-cell response delays and CSR request patterns.
// Expected timings come from parameter arithmetic; DONE-state MemReset uses a timestamp model.
// Drives inputs 1ns after the rising edge and samples there, away from the active edge.
module tb_dwc_ddrphy_memreset_seq;

  localparam int SYNC_STAGES = 2;
  localparam int PULSE_CYC   = 4;
  localparam int HOLD_CYC    = 16;
  localparam int TIMEOUT_CYC = 256;

  logic DfiClk;
  logic Reset_X;

  dwc_ddrphy_memreset_seq_if seqIf ();

  dwc_ddrphy_memreset_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .PULSE_CYC  (PULSE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .DfiClk (DfiClk),
    .Reset_X(Reset_X),
    .seqIf  (seqIf)
  );

  int passCnt  = 0;
  int totalCnt = 0;
  int failCnt  = 0;
  int cyc      = 0;

  // Pulse monitor state, sampled on the falling edge.
  int saneRun = 0, clrRun = 0, maxSane = 0, maxClr = 0;
  logic overlapSeen = 1'b0;

  initial begin
    DfiClk = 1'b0;
    forever #5 DfiClk = ~DfiClk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Track pulse run lengths and any overlap of the two POR control pulses.
  always @(negedge DfiClk) begin
    if (seqIf.SetDCTSanePulse === 1'b1 && seqIf.ClrPORMemReset === 1'b1) overlapSeen <= 1'b1;
    if (seqIf.SetDCTSanePulse === 1'b1) begin
      saneRun <= saneRun + 1;
      if (saneRun + 1 > maxSane) maxSane <= saneRun + 1;
    end else begin
      saneRun <= 0;
    end
    if (seqIf.ClrPORMemReset === 1'b1) begin
      clrRun <= clrRun + 1;
      if (clrRun + 1 > maxClr) maxClr <= clrRun + 1;
    end else begin
      clrRun <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge DfiClk);
    #1;
    cyc++;
  endtask

  task automatic startPulse();
    seqIf.SeqStart = 1'b1;
    tick();
    seqIf.SeqStart = 1'b0;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (seqIf.SeqState !== s && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic pulseWidth(input bit which, output int w);
    w = 0;
    while (((which == 1'b0) ? seqIf.SetDCTSanePulse : seqIf.ClrPORMemReset) === 1'b1 && w < 50) begin
      w++;
      tick();
    end
  endtask

  task automatic doSetSane();
    int n, w;
    waitState(3'd2, 20, n);
    check("enter_set_sane", seqIf.SeqState, 2);
    pulseWidth(1'b0, w);
    check("sane_pulse_width", w, PULSE_CYC);
    check("state_wait_sane", seqIf.SeqState, 3);
  endtask

  task automatic doSane(input bit pokeStart);
    int n, w, d;
    d = $urandom_range(15, 2);
    repeat (d) tick();
    if (pokeStart) begin
      startPulse();
      check("start_ignored_wait_sane", seqIf.SeqState, 3);
    end
    seqIf.DCTSane = 1'b1;
    waitState(3'd4, 40, n);
    check("sane_to_clr_latency", n, SYNC_STAGES + 1);
    pulseWidth(1'b1, w);
    check("clr_pulse_width", w, PULSE_CYC);
    check("state_wait_por", seqIf.SeqState, 5);
  endtask

  task automatic doPor();
    int n, d;
    d = $urandom_range(12, 1);
    repeat (d) tick();
    seqIf.PORMemReset = 1'b0;
    waitState(3'd6, 40, n);
    check("por_to_done_latency", n, SYNC_STAGES + 1);
    check("done_flag", seqIf.SeqDone, 1);
    check("done_err", seqIf.SeqErr, 0);
    check("done_busy", seqIf.SeqBusy, 0);
    check("done_memreset", seqIf.DCTMemReset, 1);
  endtask

  initial begin
    int n, riseCyc, reqCyc, runLeft;
    logic req, expLvl;

    Reset_X = 1'b1;
    seqIf.PwrOkDlyd   = 1'b0;
    seqIf.SeqStart    = 1'b0;
    seqIf.MemResetReq = 1'b1;
    seqIf.DCTSane     = 1'b0;
    seqIf.PORMemReset = 1'b1;
    #2 Reset_X = 1'b0;
    #21;
    check("rst_state", seqIf.SeqState, 0);
    check("rst_set_pulse", seqIf.SetDCTSanePulse, 0);
    check("rst_clr_pulse", seqIf.ClrPORMemReset, 0);
    check("rst_memreset", seqIf.DCTMemReset, 1);
    check("rst_busy", seqIf.SeqBusy, 0);
    check("rst_done", seqIf.SeqDone, 0);
    check("rst_err", seqIf.SeqErr, 0);
    tick();
    Reset_X = 1'b1;
    repeat (4) tick();

    // Normal flow: start before power-good, then measure power-good latency.
    startPulse();
    check("start_to_busy", seqIf.SeqBusy, 1);
    check("start_state", seqIf.SeqState, 1);
    repeat ($urandom_range(6, 1)) tick();
    check("wait_pwr_holds", seqIf.SeqState, 1);
    seqIf.PwrOkDlyd = 1'b1;
    waitState(3'd2, 20, n);
    check("pwr_to_set_latency", n, SYNC_STAGES + 1);
    doSetSane();
    doSane(1'b1);
    doPor();

    // Hold enforcement: pre-DONE high time counts, so an immediate drop is allowed.
    seqIf.MemResetReq = 1'b0;
    tick();
    check("hold_prior_cycles_count", seqIf.DCTMemReset, 0);
    seqIf.MemResetReq = 1'b1;
    tick();
    check("req_rise_next_cycle", seqIf.DCTMemReset, 1);
    riseCyc = cyc;
    repeat (11) tick();
    seqIf.MemResetReq = 1'b0;
    reqCyc = cyc;
    n = 0;
    while (seqIf.DCTMemReset === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("hold_release_delay", n, riseCyc + HOLD_CYC - reqCyc);

    // Randomized CSR request pattern against a timestamp model of the hold rule.
    expLvl = 1'b0;
    req = 1'b0;
    runLeft = 0;
    for (int i = 0; i < 120; i++) begin
      if (runLeft == 0) begin
        req = 1'($urandom_range(1, 0));
        runLeft = $urandom_range(20, 1);
      end
      runLeft--;
      seqIf.MemResetReq = req;
      tick();
      if (req) begin
        if (!expLvl) riseCyc = cyc;
        expLvl = 1'b1;
      end else if (expLvl && (cyc - riseCyc) >= HOLD_CYC) begin
        expLvl = 1'b0;
      end
      check("done_memreset_model", seqIf.DCTMemReset, expLvl);
    end

    // SeqStart is ignored in DONE.
    seqIf.MemResetReq = 1'b1;
    startPulse();
    check("start_ignored_done", seqIf.SeqState, 6);
    tick();
    check("start_ignored_done_flag", seqIf.SeqDone, 1);

    // Power loss in DONE with MemReset low forces it back high.
    seqIf.MemResetReq = 1'b0;
    repeat (HOLD_CYC + 2) tick();
    check("done_memreset_low", seqIf.DCTMemReset, 0);
    seqIf.PwrOkDlyd = 1'b0;
    waitState(3'd0, 10, n);
    check("pwrloss_done_latency", n, SYNC_STAGES + 1);
    check("pwrloss_done_memreset", seqIf.DCTMemReset, 1);
    check("pwrloss_done_flag", seqIf.SeqDone, 0);
    check("pwrloss_done_err", seqIf.SeqErr, 0);
    seqIf.MemResetReq = 1'b1;
    seqIf.DCTSane     = 1'b0;
    seqIf.PORMemReset = 1'b1;

    // Timeout in WAIT_SANE.
    repeat (3) tick();
    startPulse();
    check("restart_state", seqIf.SeqState, 1);
    seqIf.PwrOkDlyd = 1'b1;
    waitState(3'd2, 20, n);
    check("pwr_to_set_latency_2", n, SYNC_STAGES + 1);
    doSetSane();
    waitState(3'd7, TIMEOUT_CYC + 100, n);
    check("sane_timeout_cycles", n, TIMEOUT_CYC);
    check("err_flag", seqIf.SeqErr, 1);
    check("err_memreset", seqIf.DCTMemReset, 1);
    check("err_busy", seqIf.SeqBusy, 0);
    repeat (5) tick();
    check("err_sticky", seqIf.SeqErr, 1);

    // Restart from ERR clears the error and completes.
    startPulse();
    check("err_restart_state", seqIf.SeqState, 1);
    check("err_restart_clear", seqIf.SeqErr, 0);
    doSetSane();
    doSane(1'b0);
    doPor();

    // Power loss during the ClrPORMemReset pulse.
    seqIf.PwrOkDlyd = 1'b0;
    waitState(3'd0, 10, n);
    check("pwrloss_to_idle", seqIf.SeqState, 0);
    seqIf.DCTSane     = 1'b0;
    seqIf.PORMemReset = 1'b1;
    seqIf.PwrOkDlyd   = 1'b1;
    repeat (4) tick();
    startPulse();
    doSetSane();
    seqIf.DCTSane = 1'b1;
    waitState(3'd4, 20, n);
    check("enter_clr_por", seqIf.SeqState, 4);
    repeat (2) tick();
    seqIf.PwrOkDlyd = 1'b0;
    waitState(3'd0, 10, n);
    check("pwrloss_clr_latency", n, SYNC_STAGES + 1);
    check("pwrloss_clr_pulse", seqIf.ClrPORMemReset, 0);
    check("pwrloss_set_pulse", seqIf.SetDCTSanePulse, 0);
    check("pwrloss_clr_memreset", seqIf.DCTMemReset, 1);

    // Asynchronous reset in WAIT_POR, applied between clock edges.
    seqIf.DCTSane   = 1'b0;
    seqIf.PwrOkDlyd = 1'b1;
    repeat (4) tick();
    startPulse();
    doSetSane();
    doSane(1'b0);
    repeat (3) tick();
    check("pre_reset_busy", seqIf.SeqBusy, 1);
    #2 Reset_X = 1'b0;
    #1;
    check("arst_state", seqIf.SeqState, 0);
    check("arst_busy", seqIf.SeqBusy, 0);
    check("arst_done", seqIf.SeqDone, 0);
    check("arst_err", seqIf.SeqErr, 0);
    check("arst_memreset", seqIf.DCTMemReset, 1);
    check("arst_set_pulse", seqIf.SetDCTSanePulse, 0);
    check("arst_clr_pulse", seqIf.ClrPORMemReset, 0);
    tick();
    Reset_X = 1'b1;
    repeat (2) tick();

    check("max_sane_pulse", maxSane, PULSE_CYC);
    check("max_clr_pulse", maxClr, PULSE_CYC);
    check("pulse_overlap", overlapSeen, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/dwc_ddrphy_memreset_seq.md
Name: dwc_ddrphy_memreset_seq

Overview:
- Core-domain (VDD) sequencer that drives the control inputs of the I/O power-on-reset cell (dwc_ddrphy_por) and consumes its status outputs.
- After power-good, it arms the DCT reset path (SetDCTSanePulse), confirms DCTSane, then releases the POR-held memory reset (ClrPORMemReset).
- It then hands MemReset control to a CSR request, enforcing a minimum assertion time, and reports progress, timeout and error.

Parameters:
SYNC_STAGES, 2, flop depth of the synchronizers on DCTSane, PORMemReset and PwrOkDlyd (≥2)
PULSE_CYC, 4, width in DfiClk cycles of the SetDCTSanePulse and ClrPORMemReset pulses (1..255)
HOLD_CYC, 16, minimum cycles DCTMemReset stays high before it may deassert (1..255)
TIMEOUT_CYC, 256, cycles allowed in each WAIT state before error (2..65535)

Ports:
DfiClk  input  1  sequencer clock
Reset_X  input  1  asynchronous active-low reset
PwrOkDlyd  input  1  delayed VDD power-good (async, synchronized internally)
SeqStart  input  1  single-cycle request to start the sequence
MemResetReq  input  1  CSR-requested memory reset level, honoured only in DONE
DCTSane  input  1  status from POR cell (async, synchronized)
PORMemReset  input  1  status from POR cell (async, synchronized)
SetDCTSanePulse  output  1  to POR cell, sets DCTSane latch
ClrPORMemReset  output  1  to POR cell, clears PORMemReset latch
DCTMemReset  output  1  to POR cell, memory reset level after DCTSane
SeqBusy  output  1  high in states 1..5
SeqDone  output  1  high in DONE
SeqErr  output  1  sticky error
SeqState  output  3  current state encoding

Behaviour:
- Reset values (Reset_X low, asynchronous): state IDLE, SetDCTSanePulse=0, ClrPORMemReset=0, DCTMemReset=1, SeqBusy=0, SeqDone=0, SeqErr=0, counter=0, all synchronizer flops=0.
- All outputs are registered and glitch-free, because they cross into VDDQ level shifters.
- States and encodings: IDLE=0, WAIT_PWR=1, SET_SANE=2, WAIT_SANE=3, CLR_POR=4, WAIT_POR=5, DONE=6, ERR=7.
- IDLE: SeqStart=1 -> WAIT_PWR and SeqErr cleared. SeqStart is ignored in every other state except ERR.
- WAIT_PWR: synced PwrOkDlyd=1 -> SET_SANE. There is no timeout in this state.
- SET_SANE: SetDCTSanePulse=1 for exactly PULSE_CYC cycles, then 0 -> WAIT_SANE. DCTMemReset is held at 1.
- WAIT_SANE: synced DCTSane=1 -> CLR_POR. After TIMEOUT_CYC cycles without it -> ERR.
- CLR_POR: ClrPORMemReset=1 for exactly PULSE_CYC cycles -> WAIT_POR.
- WAIT_POR: synced PORMemReset=0 -> DONE. After TIMEOUT_CYC cycles without it -> ERR.
- DONE:
  - DCTMemReset follows MemResetReq.
  - A 1->0 request takes effect only once DCTMemReset has been continuously high for ≥HOLD_CYC cycles. This includes cycles spent high before DONE.
  - 0->1 takes effect on the next cycle.
- ERR: SeqErr=1 (sticky), DCTMemReset=1, pulses=0. SeqStart -> WAIT_PWR and SeqErr cleared.
- Power loss: synced PwrOkDlyd falling in states 2..6 -> IDLE next cycle, DCTMemReset=1, pulses forced 0. SeqErr is unchanged.
- Counter width is clog2(max(TIMEOUT_CYC, PULSE_CYC, HOLD_CYC))+1. It clears on every state change and saturates, never wraps.
- Hold counter counts while DCTMemReset=1, clears when it is 0, and saturates at HOLD_CYC.
- Latencies:
  - SeqStart -> SeqBusy: 1 cycle.
  - PwrOkDlyd edge -> SET_SANE: SYNC_STAGES+1 cycles.
  - DCTSane edge -> CLR_POR: SYNC_STAGES+1 cycles.
- Simultaneous events: power loss has priority over timeout, and timeout over the progress condition in the same cycle.
- SetDCTSanePulse and ClrPORMemReset are never high together.

Test Plan:
- Normal flow, defaults:
  - Reset release, PwrOkDlyd=1, SeqStart pulse.
  - SetDCTSanePulse is high exactly 4 cycles.
  - Model raises DCTSane 10 cycles later -> ClrPORMemReset is high exactly 4 cycles.
  - Model drops PORMemReset -> SeqDone=1, SeqState=6, SeqErr=0.
- Hold enforcement: in DONE, immediately after entry with DCTMemReset high 12 cycles, MemResetReq=0 -> DCTMemReset stays 1 until the 16-cycle count is met, then 0. MemResetReq=1 -> DCTMemReset=1 next cycle.
- Timeout:
  - DCTSane never rises -> ERR exactly 256 cycles after WAIT_SANE entry, SeqErr=1, DCTMemReset=1.
  - SeqStart -> SeqErr=0, sequence restarts and completes.
- Power loss mid-sequence: drop PwrOkDlyd during CLR_POR pulse -> within SYNC_STAGES+1 cycles state=0, ClrPORMemReset=0, DCTMemReset=1. No pulse exceeds 4 cycles.
- Async reset mid-operation: assert Reset_X low in WAIT_POR between clock edges -> all outputs take reset values immediately, with no DfiClk edge needed.
- Ignored start: SeqStart pulses during WAIT_SANE and DONE -> no state change, and pulse counts are unaffected.
